// File: rtl/logic_trainer_sweep.sv
// Bitwise logic trainer: debounced switch operands or a truth-table sweep, result registered.
// Switch changes reach y 4+DEB_CYCLES edges after settling; each sweep vector is held STEP_DIV enabled cycles.
module logic_trainer_sweep #(
  parameter int WIDTH      = 4,
  parameter int DEB_CYCLES = 4,
  parameter int STEP_DIV   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [WIDTH-1:0] a_sw,
  input  logic [WIDTH-1:0] b_sw,
  input  logic [2:0]       op_sel,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] cur_a,
  output logic [WIDTH-1:0] cur_b,
  output logic             busy,
  output logic             sweep_done
);
  localparam int OW  = 2 * WIDTH;
  localparam int DCW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int SDW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);
  localparam logic [SDW-1:0] DIV_LAST = SDW'(STEP_DIV - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [OW-1:0]    sync1_q, sync2_q, cand_q, stable_q;
  logic [DCW-1:0]   dcnt_q;
  logic [1:0]       state_q, state_d;
  logic [OW-1:0]    cnt_q, cnt_d;
  logic [SDW-1:0]   div_q, div_d;
  logic [OW-1:0]    opnd;
  logic [WIDTH-1:0] a_op, b_op, res;
  logic [WIDTH-1:0] y_q, cur_a_q, cur_b_q;

  // Debounce keeps running regardless of ena so the panel stays live while a sweep is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      dcnt_q   <= '0;
    end else begin
      sync1_q <= {a_sw, b_sw};
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        dcnt_q <= '0;
      end else if (dcnt_q == DEB_LAST) begin
        stable_q <= cand_q;
      end else begin
        dcnt_q <= dcnt_q + DCW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    if (ena) begin
      if (abort) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        div_d   = '0;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (div_q == DIV_LAST) begin
              div_d = '0;
              if (&cnt_q) state_d = ST_DONE;
              else        cnt_d   = cnt_q + OW'(1);
            end else begin
              div_d = div_q + SDW'(1);
            end
          end
          ST_IDLE, ST_DONE: begin
            if (start) begin
              state_d = ST_RUN;
              cnt_d   = '0;
              div_d   = '0;
            end
          end
          default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            div_d   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
    end
  end

  assign opnd = (state_q == ST_IDLE) ? stable_q : cnt_q;
  assign a_op = opnd[OW-1:WIDTH];
  assign b_op = opnd[WIDTH-1:0];

  always_comb begin
    case (op_sel)
      3'd0:    res = a_op & b_op;
      3'd1:    res = a_op | b_op;
      3'd2:    res = ~a_op;
      3'd3:    res = ~(a_op & b_op);
      3'd4:    res = ~(a_op | b_op);
      3'd5:    res = a_op ^ b_op;
      3'd6:    res = ~(a_op ^ b_op);
      default: res = b_op;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      cur_a_q <= '0;
      cur_b_q <= '0;
    end else begin
      y_q     <= res;
      cur_a_q <= a_op;
      cur_b_q <= b_op;
    end
  end

  assign y          = y_q;
  assign cur_a      = cur_a_q;
  assign cur_b      = cur_b_q;
  assign busy       = (state_q == ST_RUN);
  assign sweep_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_logic_trainer_sweep.sv
// Bench for logic_trainer_sweep: window-based debounce and elapsed-cycle sweep model plus literal checkpoints.
module tb_logic_trainer_sweep;
  localparam int W    = 4;
  localparam int DEB  = 4;
  localparam int SDIV = 8;
  localparam int NVEC = 1 << (2 * W);
  localparam logic [3:0] OPTAB [0:7] = '{4'h8, 4'hE, 4'h3, 4'h7, 4'h1, 4'h6, 4'h9, 4'hA};

  logic         clk, rst_n, ena, start, abort;
  logic [W-1:0] a_sw, b_sw, y, cur_a, cur_b;
  logic [2:0]   op_sel;
  logic         busy, sweep_done;

  int n_vec = 0;
  int n_err = 0;

  logic_trainer_sweep #(.WIDTH(W), .DEB_CYCLES(DEB), .STEP_DIV(SDIV)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .a_sw(a_sw), .b_sw(b_sw),
    .op_sel(op_sel), .start(start), .abort(abort), .y(y), .cur_a(cur_a),
    .cur_b(cur_b), .busy(busy), .sweep_done(sweep_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: stable = last value seen on DEB+1 consecutive synchronised samples;
  // sweep vector = enabled cycles since start / SDIV, mode 0 idle, 1 run, 2 done.
  logic [2*W-1:0] hist [0:DEB+1];
  logic [2*W-1:0] m_stable;
  int             m_mode, m_e;
  logic [W-1:0]   exp_y, exp_a, exp_b;

  function automatic logic [W-1:0] fop(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return b;
    endcase
  endfunction

  function automatic logic win_same();
    for (int k = 2; k <= DEB + 1; k++)
      if (hist[k] != hist[1]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [2*W-1:0] model_opnd();
    int v;
    if (m_mode == 0) return m_stable;
    if (m_mode == 2) return {2*W{1'b1}};
    v = m_e / SDIV;
    return v[2*W-1:0];
  endfunction

  function automatic logic [W-1:0] m_opa();
    logic [2*W-1:0] v;
    v = model_opnd();
    return v[2*W-1:W];
  endfunction

  function automatic logic [W-1:0] m_opb();
    logic [2*W-1:0] v;
    v = model_opnd();
    return v[W-1:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= DEB + 1; k++) hist[k] <= '0;
      m_stable <= '0;
      m_mode   <= 0;
      m_e      <= 0;
      exp_y    <= '0;
      exp_a    <= '0;
      exp_b    <= '0;
    end else begin
      exp_y <= fop(op_sel, m_opa(), m_opb());
      exp_a <= m_opa();
      exp_b <= m_opb();
      hist[0] <= {a_sw, b_sw};
      for (int k = 1; k <= DEB + 1; k++) hist[k] <= hist[k-1];
      if (win_same()) m_stable <= hist[1];
      if (ena) begin
        if (abort) begin
          m_mode <= 0;
          m_e    <= 0;
        end else if (m_mode != 1 && start) begin
          m_mode <= 1;
          m_e    <= 0;
        end else if (m_mode == 1) begin
          if (m_e + 1 == NVEC * SDIV) m_mode <= 2;
          m_e <= m_e + 1;
        end
      end
    end
  end

  function automatic logic [31:0] outs();
    return {18'd0, y, cur_a, cur_b, busy, sweep_done};
  endfunction

  function automatic logic [31:0] pack(input logic [W-1:0] ey, input logic [W-1:0] ea,
                                       input logic [W-1:0] eb, input logic eby, input logic edn);
    return {18'd0, ey, ea, eb, eby, edn};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_model();
    chk("model", outs(), pack(exp_y, exp_a, exp_b, m_mode == 1, m_mode == 2));
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0;
    a_sw = '0; b_sw = '0; op_sel = 3'd3;
    repeat (2) @(negedge clk);
    chk("reset", outs(), pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
    cmp_model();
    rst_n = 1'b1;
    tick();
    chk("nand_edge1", outs(), pack(4'hF, 4'h0, 4'h0, 1'b0, 1'b0));

    // Manual path: XOR lands exactly at edge 4+DEB
    a_sw = 4'hC; b_sw = 4'hA; op_sel = 3'd5;
    repeat (7) tick();
    chk("man_edge7", {28'd0, y}, 32'h0);
    tick();
    chk("man_edge8", outs(), pack(4'h6, 4'hC, 4'hA, 1'b0, 1'b0));
    op_sel = 3'd0;
    tick();
    chk("man_and", {28'd0, y}, 32'h8);

    a_sw = 4'hD;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("glitch_hi", {28'd0, y}, 32'h8);
    end
    a_sw = 4'hC;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_lo", {28'd0, y}, 32'h8);
    end

    for (int i = 0; i < 8; i++) begin
      op_sel = 3'(i);
      tick();
      chk("op_table", {28'd0, y}, {28'd0, OPTAB[i]});
    end
    op_sel = 3'd0;
    tick();

    // Full sweep with AND
    pulse_start();
    chk("sweep_busy", outs(), pack(4'h8, 4'hC, 4'hA, 1'b1, 1'b0));
    tick();
    chk("sweep_v00", outs(), pack(4'h0, 4'h0, 4'h0, 1'b1, 1'b0));
    repeat (8) tick();
    chk("sweep_v01", outs(), pack(4'h0, 4'h0, 4'h1, 1'b1, 1'b0));
    repeat (432) tick();
    chk("sweep_v37", outs(), pack(4'h3, 4'h3, 4'h7, 1'b1, 1'b0));
    repeat (1606) tick();
    chk("sweep_2047", outs(), pack(4'hF, 4'hF, 4'hF, 1'b1, 1'b0));
    tick();
    chk("sweep_done", outs(), pack(4'hF, 4'hF, 4'hF, 1'b0, 1'b1));
    repeat (5) tick();
    chk("done_hold", outs(), pack(4'hF, 4'hF, 4'hF, 1'b0, 1'b1));

    // Restart from DONE, then abort together with start at vector 0x37
    pulse_start();
    repeat (441) tick();
    chk("restart_v37", outs(), pack(4'h3, 4'h3, 4'h7, 1'b1, 1'b0));
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("abort_edge", outs(), pack(4'h3, 4'h3, 4'h7, 1'b0, 1'b0));
    tick();
    chk("abort_sw", outs(), pack(4'h8, 4'hC, 4'hA, 1'b0, 1'b0));

    // ena low for 20 cycles mid-run; an abort during the freeze is ignored
    pulse_start();
    repeat (100) tick();
    chk("pre_freeze", outs(), pack(4'h0, 4'h0, 4'hC, 1'b1, 1'b0));
    ena = 1'b0;
    repeat (5) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (14) tick();
    chk("frozen", outs(), pack(4'h0, 4'h0, 4'hC, 1'b1, 1'b0));
    ena = 1'b1;
    repeat (1947) tick();
    chk("late_2067", {31'd0, sweep_done}, 32'h0);
    tick();
    chk("late_2068", outs(), pack(4'hF, 4'hF, 4'hF, 1'b0, 1'b1));

    // Asynchronous reset between edges mid-run
    pulse_start();
    repeat (50) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", outs(), 32'h0);
    cmp_model();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) tick();
    chk("post_rst_e7", outs(), pack(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
    tick();
    chk("post_rst_e8", outs(), pack(4'h8, 4'hC, 4'hA, 1'b0, 1'b0));
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
